pulse_decoder: RTL and testbench

PULSE_DECODER -- requirements
Module: pulse_decoder

---
 rtl/pulse_decoder_pkg.sv | 18 +
 rtl/pulse_decoder.sv | 104 ++++++++++
 tb/tb_pulse_decoder.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_decoder_pkg.sv
// rtl/pulse_decoder_pkg.sv - shared state encodings and pulse-width constants for pulse_decoder
package pulse_decoder_pkg;

  typedef enum logic [1:0] {
    ARM  = 2'd0,
    IDLE = 2'd1,
    HIGH = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam int GAP_MIN_DEF = 4;
  localparam int CNT_W_DEF   = 8;

  localparam logic [2:0] W_SHORT = 3'd1;
  localparam logic [2:0] W_LONG  = 3'd2;
  localparam logic [2:0] W_SAT   = 3'd7;

endpackage

// File: rtl/pulse_decoder.sv
// rtl/pulse_decoder.sv - classifies 1/2-cycle pulses on a serial line, flags overlong pulses and short gaps
module pulse_decoder
  import pulse_decoder_pkg::*;
#(
  parameter int GAP_MIN = GAP_MIN_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inp,
  output logic             valid,
  output logic             long_p,
  output logic             err,
  output logic [CNT_W-1:0] evt_cnt
);

  localparam int GAP_W = (GAP_MIN < 2) ? 1 : $clog2(GAP_MIN + 1);

  state_t           state, state_d;
  logic [2:0]       width_q, width_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             valid_d, err_d, long_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ARM;
      width_q <= '0;
      gap_q   <= '0;
    end else begin
      state   <= state_d;
      width_q <= width_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state;
    width_d = width_q;
    gap_d   = gap_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    long_d  = long_p;
    case (state)
      ARM: begin
        if (!inp) state_d = IDLE;
      end
      IDLE: begin
        if (inp) begin
          state_d = HIGH;
          width_d = W_SHORT;
        end
      end
      HIGH: begin
        if (inp) begin
          if (width_q != W_SAT) width_d = width_q + 3'd1;
        end else begin
          if (width_q == W_SHORT || width_q == W_LONG) begin
            valid_d = 1'b1;
            long_d  = (width_q == W_LONG);
          end else begin
            err_d = 1'b1;
          end
          width_d = '0;
          // The falling sample is the first low of the gap.
          gap_d   = GAP_W'(1);
          state_d = (GAP_MIN <= 1) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (inp) begin
          err_d   = 1'b1;
          state_d = HIGH;
          width_d = W_SHORT;
          gap_d   = '0;
        end else if (gap_q >= GAP_W'(GAP_MIN - 1)) begin
          state_d = IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = ARM;
        width_d = '0;
        gap_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      err     <= 1'b0;
      long_p  <= 1'b0;
      evt_cnt <= '0;
    end else begin
      valid  <= valid_d;
      err    <= err_d;
      long_p <= long_d;
      if (valid_d) evt_cnt <= evt_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pulse_decoder.sv
// tb/tb_pulse_decoder.sv - randomized self-checking bench for pulse_decoder against a run-length model
module tb_pulse_decoder;
  import pulse_decoder_pkg::*;

  localparam int GAP_MIN = GAP_MIN_DEF;
  localparam int CNT_W   = CNT_W_DEF;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             inp = 1'b0;
  logic             valid, long_p, err;
  logic [CNT_W-1:0] evt_cnt;

  int n_pass = 0;
  int n_total = 0;

  pulse_decoder #(.GAP_MIN(GAP_MIN), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .inp(inp),
    .valid(valid), .long_p(long_p), .err(err), .evt_cnt(evt_cnt)
  );

  always #5 clk = ~clk;

  // Model works on run lengths: highs in the current pulse, lows since the last pulse ended.
  bit               armed;
  int               high_run, low_run;
  logic             m_valid, m_err, m_long;
  logic [CNT_W-1:0] m_cnt;

  task automatic model_reset();
    armed = 0; high_run = 0; low_run = 0;
    m_valid = 0; m_err = 0; m_long = 0; m_cnt = '0;
  endtask

  task automatic model_step(input logic s);
    m_valid = 0; m_err = 0;
    if (!armed) begin
      if (!s) begin armed = 1; low_run = GAP_MIN; end
    end else if (s) begin
      if (high_run == 0 && low_run < GAP_MIN) m_err = 1;
      high_run++;
    end else if (high_run > 0) begin
      if (high_run <= 2) begin
        m_valid = 1; m_long = (high_run == 2); m_cnt = m_cnt + 1'b1;
      end else m_err = 1;
      high_run = 0; low_run = 1;
    end else low_run++;
  endtask

  task automatic drive(input logic v);
    @(negedge clk);
    inp = v;
    @(posedge clk);
    model_step(v);
    #1;
  endtask

  task automatic do_reset(input logic v);
    @(negedge clk);
    rst_n = 1'b0; inp = v;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    drive(1'b0); drive(1'b1);
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({valid, err, long_p, evt_cnt} !== '0)
      $display("FAIL reset_async: got v=%b e=%b l=%b c=%0d required all 0", valid, err, long_p, evt_cnt);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_short();
    string seq = "0010000";
    do_reset(1'b0);
    for (int i = 0; i < seq.len(); i++) begin
      drive(seq[i] == "1");
      n_total++;
      if ({valid, err, long_p, evt_cnt} !== {m_valid, m_err, m_long, m_cnt})
        $display("FAIL short[%0d]: got v=%b e=%b l=%b c=%0d required v=%b e=%b l=%b c=%0d",
                 i, valid, err, long_p, evt_cnt, m_valid, m_err, m_long, m_cnt);
      else n_pass++;
    end
    n_total++;
    if (evt_cnt !== CNT_W'(1)) $display("FAIL short_cnt: got %0d required 1", evt_cnt);
    else n_pass++;
  endtask

  task automatic test_long();
    string seq = "110000";
    for (int i = 0; i < seq.len(); i++) begin
      drive(seq[i] == "1");
      n_total++;
      if ({valid, err, long_p, evt_cnt} !== {m_valid, m_err, m_long, m_cnt})
        $display("FAIL long[%0d]: got v=%b e=%b l=%b c=%0d required v=%b e=%b l=%b c=%0d",
                 i, valid, err, long_p, evt_cnt, m_valid, m_err, m_long, m_cnt);
      else n_pass++;
    end
    n_total++;
    if (u_dut.state !== IDLE) $display("FAIL long_state: got %0d required %0d", u_dut.state, IDLE);
    else n_pass++;
  endtask

  task automatic test_too_long();
    string seq = "11111000000";
    for (int i = 0; i < seq.len(); i++) begin
      drive(seq[i] == "1");
      n_total++;
      if ({valid, err, long_p, evt_cnt} !== {m_valid, m_err, m_long, m_cnt})
        $display("FAIL too_long[%0d]: got v=%b e=%b l=%b c=%0d required v=%b e=%b l=%b c=%0d",
                 i, valid, err, long_p, evt_cnt, m_valid, m_err, m_long, m_cnt);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    string seq = "1001000000";
    for (int i = 0; i < seq.len(); i++) begin
      drive(seq[i] == "1");
      n_total++;
      if ({valid, err, long_p, evt_cnt} !== {m_valid, m_err, m_long, m_cnt})
        $display("FAIL back_to_back[%0d]: got v=%b e=%b l=%b c=%0d required v=%b e=%b l=%b c=%0d",
                 i, valid, err, long_p, evt_cnt, m_valid, m_err, m_long, m_cnt);
      else n_pass++;
    end
  endtask

  task automatic test_high_at_reset();
    string seq = "11101000000";
    do_reset(1'b1);
    for (int i = 0; i < seq.len(); i++) begin
      drive(seq[i] == "1");
      n_total++;
      if ({valid, err, long_p, evt_cnt} !== {m_valid, m_err, m_long, m_cnt})
        $display("FAIL high_at_reset[%0d]: got v=%b e=%b l=%b c=%0d required v=%b e=%b l=%b c=%0d",
                 i, valid, err, long_p, evt_cnt, m_valid, m_err, m_long, m_cnt);
      else n_pass++;
    end
    n_total++;
    if (evt_cnt !== CNT_W'(1)) $display("FAIL high_at_reset_cnt: got %0d required 1", evt_cnt);
    else n_pass++;
  endtask

  task automatic test_wrap_and_reset();
    int bad = 0;
    do_reset(1'b0);
    drive(1'b0);
    for (int p = 0; p < (1 << CNT_W); p++) begin
      int w = $urandom_range(1, 2);
      int g = $urandom_range(GAP_MIN, GAP_MIN + 2);
      for (int k = 0; k < w + g; k++) begin
        drive(k < w);
        if ({valid, err, long_p, evt_cnt} !== {m_valid, m_err, m_long, m_cnt}) begin
          if (bad < 5)
            $display("FAIL wrap[%0d.%0d]: got v=%b e=%b l=%b c=%0d required v=%b e=%b l=%b c=%0d",
                     p, k, valid, err, long_p, evt_cnt, m_valid, m_err, m_long, m_cnt);
          bad++;
        end
      end
    end
    n_total++;
    if (bad != 0) $display("FAIL wrap_steps: got %0d bad cycles required 0", bad);
    else n_pass++;
    n_total++;
    if (evt_cnt !== '0) $display("FAIL wrap_cnt: got %0d required 0", evt_cnt);
    else n_pass++;
    // Abort a pulse mid-way; nothing may come out of it after release.
    drive(1'b1);
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({valid, err, long_p, evt_cnt} !== '0)
      $display("FAIL mid_pulse_reset: got v=%b e=%b l=%b c=%0d required all 0", valid, err, long_p, evt_cnt);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0);
      n_total++;
      if ({valid, err, long_p, evt_cnt} !== '0)
        $display("FAIL post_reset[%0d]: got v=%b e=%b l=%b c=%0d required all 0", i, valid, err, long_p, evt_cnt);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int bad = 0;
    int steps = 0;
    do_reset($urandom_range(0, 1));
    while (steps < 1500) begin
      int h = $urandom_range(1, 4);
      int l = $urandom_range(1, GAP_MIN + 2);
      for (int k = 0; k < h + l; k++) begin
        drive(k < h);
        steps++;
        n_total++;
        if ({valid, err, long_p, evt_cnt} !== {m_valid, m_err, m_long, m_cnt}) begin
          if (bad < 5)
            $display("FAIL random[%0d]: got v=%b e=%b l=%b c=%0d required v=%b e=%b l=%b c=%0d",
                     steps, valid, err, long_p, evt_cnt, m_valid, m_err, m_long, m_cnt);
          bad++;
        end else n_pass++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_short();
    test_long();
    test_too_long();
    test_back_to_back();
    test_high_at_reset();
    test_wrap_and_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
